// File: rtl/ms_countdown_timer_pkg.sv
// Shared types and constants for the seconds countdown timer and its display stage.
// Combinational helpers only; no latency, no backpressure.
package ms_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int          BCD_W             = 4;
  localparam logic [7:0]  BCD_ZERO          = 8'h00;
  localparam int          WARN_TOGGLE_TICKS = 250;

  // Saturate each nibble of a BCD pair to 9 so illegal load values still display.
  function automatic logic [2*BCD_W-1:0] bcd_clamp(input logic [2*BCD_W-1:0] v);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
    tens = (v[2*BCD_W-1:BCD_W] > 4'd9) ? 4'd9 : v[2*BCD_W-1:BCD_W];
    ones = (v[BCD_W-1:0] > 4'd9) ? 4'd9 : v[BCD_W-1:0];
    return {tens, ones};
  endfunction

endpackage

// File: rtl/ms_countdown_timer_if.sv
// Command/status bundle between game control and the countdown timer; LOW_TIME_WARN_EN adds warnBlink.
// Pure wiring: no latency, pulses are single-cycle with no backpressure.
interface ms_countdown_timer_if;

  logic       oneMsTimeout;
  logic       load;
  logic [7:0] loadVal;
  logic       start;
  logic       pause;
  logic       timerEnable;
  logic [3:0] secTens;
  logic [3:0] secOnes;
  logic       running;
  logic       timeUp;
`ifdef LOW_TIME_WARN_EN
  logic       warnBlink;
`endif

  modport master (
`ifdef LOW_TIME_WARN_EN
    input  warnBlink,
`endif
    output oneMsTimeout, load, loadVal, start, pause,
    input  timerEnable, secTens, secOnes, running, timeUp
  );

  modport slave (
`ifdef LOW_TIME_WARN_EN
    output warnBlink,
`endif
    input  oneMsTimeout, load, loadVal, start, pause,
    output timerEnable, secTens, secOnes, running, timeUp
  );

endinterface

// File: rtl/ms_countdown_timer_bcd_dec.sv
// Two-digit BCD decrement that saturates at 00; is_zero flags a 00 result.
// Purely combinational, no backpressure.
module bcd_sec_decrement
  import ms_timer_pkg::*;
(
  input  logic [2*BCD_W-1:0] digits_in,
  output logic [2*BCD_W-1:0] digits_out,
  output logic               is_zero
);

  logic [BCD_W-1:0] tens_in;
  logic [BCD_W-1:0] ones_in;

  assign tens_in = digits_in[2*BCD_W-1:BCD_W];
  assign ones_in = digits_in[BCD_W-1:0];

  always_comb begin
    digits_out = digits_in;
    if (digits_in != BCD_ZERO) begin
      if (ones_in == 4'd0) begin
        digits_out = {tens_in - 4'd1, 4'd9};
      end else begin
        digits_out = {tens_in, ones_in - 4'd1};
      end
    end
  end

  assign is_zero = (digits_out == BCD_ZERO);

endmodule

// File: rtl/ms_countdown_timer.sv
// BCD seconds countdown driven by 1 ms ticks; status outputs are registered (one cycle behind state); LOW_TIME_WARN_EN adds warnBlink.
// No backpressure: every tick and command pulse is acted on or discarded in the cycle it arrives.
module ms_countdown_timer
  import ms_timer_pkg::*;
#(
  parameter int         MS_PER_TICK = 1000,
  parameter logic [7:0] START_SEC   = 8'h60
) (
  input  logic               clk,
  input  logic               rst,
  ms_countdown_timer_if.slave tif
);

  localparam int             MS_W    = (MS_PER_TICK > 1) ? $clog2(MS_PER_TICK) : 1;
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_PER_TICK - 1);
  localparam logic [MS_W-1:0] MS_ONE  = MS_W'(1);

  state_t          state_q, state_d;
  logic [7:0]      digits_q, digits_d;
  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
  logic            running_q, running_d;
  logic            timer_en_q, timer_en_d;
  logic            time_up_q, time_up_d;

  logic [7:0]      dec_digits;
  logic            dec_is_zero;
  logic            sec_done;

  bcd_sec_decrement u_dec (
    .digits_in  (digits_q),
    .digits_out (dec_digits),
    .is_zero    (dec_is_zero)
  );

  assign sec_done = tif.oneMsTimeout && (ms_cnt_q == MS_LAST);

  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    ms_cnt_d   = ms_cnt_q;
    time_up_d  = 1'b0;
    running_d  = (state_q == ST_RUN);
    timer_en_d = (state_q == ST_RUN);

    if (tif.load) begin
      digits_d = bcd_clamp(tif.loadVal);
      ms_cnt_d = '0;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!tif.pause && tif.start && (digits_q != BCD_ZERO)) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (tif.oneMsTimeout) begin
            ms_cnt_d = sec_done ? '0 : ms_cnt_q + MS_ONE;
          end
          if (sec_done) begin
            digits_d = dec_digits;
          end
          // A tick coinciding with pause is counted first, so it can still expire the round.
          if (sec_done && dec_is_zero) begin
            state_d   = ST_DONE;
            time_up_d = 1'b1;
          end else if (tif.pause) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (!tif.pause && tif.start) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      digits_q   <= START_SEC;
      ms_cnt_q   <= '0;
      running_q  <= 1'b0;
      timer_en_q <= 1'b0;
      time_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      ms_cnt_q   <= ms_cnt_d;
      running_q  <= running_d;
      timer_en_q <= timer_en_d;
      time_up_q  <= time_up_d;
    end
  end

  assign tif.secTens     = digits_q[2*BCD_W-1:BCD_W];
  assign tif.secOnes     = digits_q[BCD_W-1:0];
  assign tif.running     = running_q;
  assign tif.timerEnable = timer_en_q;
  assign tif.timeUp      = time_up_q;

`ifdef LOW_TIME_WARN_EN
  localparam logic [7:0] WARN_LAST = 8'(WARN_TOGGLE_TICKS - 1);

  logic [7:0] warn_cnt_q, warn_cnt_d;
  logic       warn_q, warn_d;

  always_comb begin
    warn_cnt_d = '0;
    warn_d     = 1'b0;
    if ((state_q == ST_RUN) && (digits_q <= 8'h10)) begin
      warn_cnt_d = warn_cnt_q;
      warn_d     = warn_q;
      if (tif.oneMsTimeout) begin
        if (warn_cnt_q == WARN_LAST) begin
          warn_cnt_d = '0;
          warn_d     = ~warn_q;
        end else begin
          warn_cnt_d = warn_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      warn_cnt_q <= '0;
      warn_q     <= 1'b0;
    end else begin
      warn_cnt_q <= warn_cnt_d;
      warn_q     <= warn_d;
    end
  end

  assign tif.warnBlink = warn_q;
`endif

endmodule

// File: tb/tb_ms_countdown_timer.sv
// Directed bench for ms_countdown_timer with an integer-seconds reference model checked every cycle.
// Literal checks after each scenario pin the model to hand-computed values.
module tb_ms_countdown_timer;

  localparam int         MS    = 4;
  localparam logic [7:0] START = 8'h60;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clk;
  logic rst;
  bit   check_en;
  int   vectors;
  int   miscompares;

  ms_countdown_timer_if tif ();

  ms_countdown_timer #(
    .MS_PER_TICK (MS),
    .START_SEC   (START)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tif (tif)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: remaining seconds as a plain integer, a ms counter and a mode.
  int m_secs;
  int m_ms;
  int m_mode;
  bit m_running;
  bit m_timeup;
`ifdef LOW_TIME_WARN_EN
  int m_wcnt;
  bit m_blink;
`endif

  function automatic int clamp_bcd(input logic [7:0] v);
    int t;
    int o;
    t = int'(v[7:4]);
    o = int'(v[3:0]);
    if (t > 9) t = 9;
    if (o > 9) o = 9;
    return t * 10 + o;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_secs    = clamp_bcd(START);
      m_ms      = 0;
      m_mode    = M_IDLE;
      m_running = 1'b0;
      m_timeup  = 1'b0;
`ifdef LOW_TIME_WARN_EN
      m_wcnt    = 0;
      m_blink   = 1'b0;
`endif
    end else begin
`ifdef LOW_TIME_WARN_EN
      if (m_mode == M_RUN && m_secs <= 10) begin
        if (tif.oneMsTimeout) begin
          m_wcnt++;
          if (m_wcnt == 250) begin
            m_wcnt  = 0;
            m_blink = ~m_blink;
          end
        end
      end else begin
        m_wcnt  = 0;
        m_blink = 1'b0;
      end
`endif
      m_running = (m_mode == M_RUN);
      m_timeup  = 1'b0;
      if (tif.load) begin
        m_secs = clamp_bcd(tif.loadVal);
        m_ms   = 0;
        m_mode = M_IDLE;
      end else if (m_mode == M_RUN) begin
        if (tif.oneMsTimeout) begin
          m_ms++;
          if (m_ms == MS) begin
            m_ms = 0;
            if (m_secs > 0) m_secs--;
            if (m_secs == 0) begin
              m_mode   = M_DONE;
              m_timeup = 1'b1;
            end
          end
        end
        if (tif.pause && m_mode == M_RUN) m_mode = M_PAUSE;
      end else if (m_mode == M_IDLE) begin
        if (tif.start && !tif.pause && m_secs != 0) m_mode = M_RUN;
      end else if (m_mode == M_PAUSE) begin
        if (tif.start && !tif.pause) m_mode = M_RUN;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h, required %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_tens",    {4'h0, tif.secTens}, 8'(m_secs / 10));
      chk("model_ones",    {4'h0, tif.secOnes}, 8'(m_secs % 10));
      chk("model_running", {7'h0, tif.running}, {7'h0, m_running});
      chk("model_ten",     {7'h0, tif.timerEnable}, {7'h0, m_running});
      chk("model_timeup",  {7'h0, tif.timeUp}, {7'h0, m_timeup});
`ifdef LOW_TIME_WARN_EN
      chk("model_warn",    {7'h0, tif.warnBlink}, {7'h0, m_blink});
`endif
    end
  end

  task automatic cyc(input bit tk, input bit ld, input logic [7:0] v, input bit st, input bit ps);
    tif.oneMsTimeout = tk;
    tif.load         = ld;
    tif.loadVal      = v;
    tif.start        = st;
    tif.pause        = ps;
    @(posedge clk);
    #1;
    tif.oneMsTimeout = 1'b0;
    tif.load         = 1'b0;
    tif.start        = 1'b0;
    tif.pause        = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_load(input logic [7:0] v);
    cyc(1'b0, 1'b1, v, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic chk_digits(input string name, input logic [7:0] exp);
    chk(name, {tif.secTens, tif.secOnes}, exp);
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    check_en         = 1'b0;
    rst              = 1'b0;
    tif.oneMsTimeout = 1'b0;
    tif.load         = 1'b0;
    tif.loadVal      = 8'h00;
    tif.start        = 1'b0;
    tif.pause        = 1'b0;

    @(posedge clk);
    #1;
    check_en = 1'b1;
    @(posedge clk);
    #1;
    chk_digits("rst_digits", 8'h60);
    chk("rst_running", {7'h0, tif.running}, 8'h00);
    chk("rst_ten",     {7'h0, tif.timerEnable}, 8'h00);
    chk("rst_timeup",  {7'h0, tif.timeUp}, 8'h00);
    rst = 1'b1;

    // Basic countdown 03 -> 00
    do_load(8'h03);
    do_start();
    chk("run_rise", {7'h0, tif.running}, 8'h00);
    ticks(3);
    chk_digits("cd_tick3", 8'h03);
    ticks(1);
    chk_digits("cd_tick4", 8'h02);
    ticks(4);
    chk_digits("cd_tick8", 8'h01);
    ticks(3);
    chk("cd_no_timeup", {7'h0, tif.timeUp}, 8'h00);
    ticks(1);
    chk_digits("cd_tick12", 8'h00);
    chk("cd_timeup", {7'h0, tif.timeUp}, 8'h01);
    chk("cd_run_hold", {7'h0, tif.running}, 8'h01);
    idle();
    chk("cd_timeup_end", {7'h0, tif.timeUp}, 8'h00);
    chk("cd_run_fall", {7'h0, tif.running}, 8'h00);
    do_start();
    idle();
    chk_digits("done_start", 8'h00);
    chk("done_running", {7'h0, tif.running}, 8'h00);

    // Borrow 10 -> 09
    do_load(8'h10);
    do_start();
    ticks(4);
    chk_digits("borrow", 8'h09);

    // Pause holds digits and ms count
    do_load(8'h05);
    do_start();
    ticks(2);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    ticks(10);
    chk_digits("pause_hold", 8'h05);
    chk("pause_running", {7'h0, tif.running}, 8'h00);
    do_start();
    ticks(2);
    chk_digits("resume", 8'h04);

    // Start with 00 is ignored; clamped load
    do_load(8'h00);
    do_start();
    idle();
    chk("zero_start_ten", {7'h0, tif.timerEnable}, 8'h00);
    do_load(8'hAF);
    chk_digits("clamp", 8'h99);

    // Load wins over a same-cycle tick and clears the ms count
    do_load(8'h07);
    do_start();
    ticks(2);
    cyc(1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
    chk_digits("load_tick", 8'h42);
    idle();
    chk("load_idle", {7'h0, tif.running}, 8'h00);
    do_start();
    ticks(3);
    chk_digits("load_ms0_a", 8'h42);
    ticks(1);
    chk_digits("load_ms0_b", 8'h41);

    // Final tick together with pause still expires
    do_load(8'h01);
    do_start();
    ticks(3);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk_digits("pause_final", 8'h00);
    chk("pause_final_tu", {7'h0, tif.timeUp}, 8'h01);
    idle();
    do_start();
    idle();
    chk("pause_final_done", {7'h0, tif.running}, 8'h00);
    chk_digits("pause_final_dig", 8'h00);

    idle();
    idle();
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
